// File: rtl/seq_det_pkg.sv
// Shared types and reset defaults for the multi-channel serial pattern detector.
//   NUM_CH_DEF / MAX_LEN_DEF : default channel count and maximum pattern length;
//                              the context record and channel index are sized from them
//   DEFAULT_*                : configuration loaded at reset
//   ch_idx_t                 : channel index
//   ch_ctx_t                 : per-channel context {bit history, fill count}
package seq_det_pkg;

  localparam int unsigned NUM_CH_DEF  = 4;
  localparam int unsigned MAX_LEN_DEF = 8;
  localparam int unsigned CH_W_DEF    = $clog2(NUM_CH_DEF);
  localparam int unsigned LEN_W_DEF   = $clog2(MAX_LEN_DEF + 1);

  localparam logic [MAX_LEN_DEF-1:0] DEFAULT_PATTERN = MAX_LEN_DEF'(5'b11011);
  localparam logic [LEN_W_DEF-1:0]   DEFAULT_LEN     = LEN_W_DEF'(5);
  localparam logic                   DEFAULT_OVERLAP = 1'b1;

  typedef logic [CH_W_DEF-1:0] ch_idx_t;

  typedef struct packed {
    logic [MAX_LEN_DEF-1:0] hist;
    logic [LEN_W_DEF-1:0]   fill;
  } ch_ctx_t;

endpackage

// File: rtl/seq_det_scheduler_rr_arbiter.sv
// Round-robin arbiter holding the rotating priority pointer.
//   clk, rst : clock, synchronous active-high reset (pointer -> 0)
//   req_i    : per-channel request
//   adv_i    : a grant was consumed this cycle; move pointer past the winner
//   gnt_o    : one-hot grant, first requester at or after the pointer (wrapping)
//   idx_o    : index of the granted channel (0 when nothing is granted)
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              adv_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [CH_W-1:0]   idx_o
);

  logic [CH_W-1:0] ptr_q, ptr_d;
  logic            found;
  int unsigned     cand;
  logic [CH_W-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand     = (32'(ptr_q) + k) % NUM_CH;
      cand_idx = CH_W'(cand);
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = (idx_o == CH_W'(NUM_CH - 1)) ? '0 : idx_o + CH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/seq_det_scheduler.sv
// One programmable serial pattern matcher time-shared across NUM_CH bit-serial
// channels. A round-robin arbiter accepts one bit per cycle; each channel keeps
// its own history/fill context so interleaved streams match independently.
//   clk, rst            : clock, synchronous active-high reset
//   cfg_we              : load cfg_pattern/cfg_len/cfg_overlap, clear all fills
//   cfg_pattern         : pattern, first-received bit at [len-1], last at [0]
//   cfg_len             : pattern length (0 disables, >MAX_LEN clamps)
//   cfg_overlap         : 1 = overlapping matches, 0 = restart after a match
//   ch_valid, ch_bit    : per-channel serial bit and its valid
//   ch_ready            : one-hot grant (combinational)
//   match_valid/match_ch: registered match pulse and its channel tag
//   count_clr           : clear match counter (wins over increment)
//   match_count         : saturating match count
// The context record and channel index come from seq_det_pkg; NUM_CH/MAX_LEN
// overrides must stay consistent with the package constants.
module seq_det_scheduler
  import seq_det_pkg::*;
#(
  parameter int unsigned NUM_CH  = NUM_CH_DEF,
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned CH_W    = $clog2(NUM_CH),
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [NUM_CH-1:0]  ch_valid,
  input  logic [NUM_CH-1:0]  ch_bit,
  output logic [NUM_CH-1:0]  ch_ready,
  output logic               match_valid,
  output logic [CH_W-1:0]    match_ch,
  input  logic               count_clr,
  output logic [CNT_W-1:0]   match_count
);

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q;

  ch_ctx_t            ctx_q [NUM_CH];
  ch_ctx_t            ctx_d [NUM_CH];

  logic [NUM_CH-1:0]  req, gnt;
  ch_idx_t            gidx;
  logic               xfer;

  logic [MAX_LEN-1:0] new_hist;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W:0]     fill_inc;
  logic               hit;

  logic               match_valid_q;
  logic [CH_W-1:0]    match_ch_q;
  logic [CNT_W-1:0]   count_q;

  // A config write blocks all grants so no bit is matched against a half-loaded setup.
  assign req = cfg_we ? '0 : ch_valid;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (req),
    .adv_i (xfer),
    .gnt_o (gnt),
    .idx_o (gidx)
  );

  assign ch_ready = gnt;
  assign xfer     = |(gnt & ch_valid);

  assign len_d = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;

  // Compare the granted channel's post-shift history against the low len bits.
  always_comb begin
    new_hist = {ctx_q[gidx].hist[MAX_LEN-2:0], ch_bit[gidx]};
    fill_inc = {1'b0, ctx_q[gidx].fill} + (LEN_W + 1)'(1);
    len_mask = ~({MAX_LEN{1'b1}} << len_q);
    hit      = xfer && (len_q != '0) && (fill_inc >= {1'b0, len_q})
               && (((new_hist ^ pattern_q) & len_mask) == '0);
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ctx_d[i] = ctx_q[i];
    end
    if (cfg_we) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        ctx_d[i].fill = '0;
      end
    end else if (xfer) begin
      ctx_d[gidx].hist = new_hist;
      if (hit && !overlap_q) begin
        ctx_d[gidx].fill = '0;
      end else if (fill_inc >= {1'b0, len_q}) begin
        ctx_d[gidx].fill = len_q;
      end else begin
        ctx_d[gidx].fill = fill_inc[LEN_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= MAX_LEN'(DEFAULT_PATTERN);
      len_q     <= LEN_W'(DEFAULT_LEN);
      overlap_q <= DEFAULT_OVERLAP;
    end else if (cfg_we) begin
      pattern_q <= cfg_pattern;
      len_q     <= len_d;
      overlap_q <= cfg_overlap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        ctx_q[i] <= '0;
      end
    end else begin
      ctx_q <= ctx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match_valid_q <= 1'b0;
      match_ch_q    <= '0;
    end else begin
      match_valid_q <= hit;
      if (hit) begin
        match_ch_q <= gidx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || count_clr) begin
      count_q <= '0;
    end else if (match_valid_q && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign match_valid = match_valid_q;
  assign match_ch    = match_ch_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_seq_det_scheduler.sv
module tb_seq_det_scheduler;

  localparam int NCH  = 4;
  localparam int ML   = 8;
  localparam int CW   = 10;
  localparam int CMAX = (1 << CW) - 1;
  localparam int SEQN = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [ML-1:0] cfg_pattern;
  logic [3:0]    cfg_len;
  logic          cfg_overlap;
  logic [NCH-1:0] ch_valid, ch_bit, ch_ready;
  logic          match_valid;
  logic [1:0]    match_ch;
  logic          count_clr;
  logic [CW-1:0] match_count;

  always #5 clk = ~clk;

  seq_det_scheduler #(
    .NUM_CH  (NCH),
    .MAX_LEN (ML),
    .CNT_W   (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .ch_valid    (ch_valid),
    .ch_bit      (ch_bit),
    .ch_ready    (ch_ready),
    .match_valid (match_valid),
    .match_ch    (match_ch),
    .count_clr   (count_clr),
    .match_count (match_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: full received-bit log per channel, bits counted since the
  // last config write / restart, and the configured rules applied directly.
  int       m_ptr;
  bit [7:0] m_pat;
  int       m_len;
  bit       m_ovl;
  int       m_fresh [NCH];
  int       m_n     [NCH];
  bit       m_seq   [NCH][SEQN];
  int       m_cnt;
  bit       m_mv;
  int       m_mch;

  logic [NCH-1:0] exp_ready, obs_ready;
  logic           exp_mv, obs_mv;
  logic [1:0]     exp_mch, obs_mch;
  logic [CW-1:0]  exp_cnt, obs_cnt;

  task automatic model_reset();
    m_ptr = 0; m_pat = 8'b0001_1011; m_len = 5; m_ovl = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      m_fresh[i] = 0; m_n[i] = 0;
    end
    m_cnt = 0; m_mv = 1'b0; m_mch = 0;
  endtask

  // One clock: drive inputs at negedge, sample ch_ready before the edge,
  // advance the model at the edge, sample registered outputs after it.
  task automatic tick(input logic [NCH-1:0] v, input logic [NCH-1:0] b, input logic we,
                      input logic [7:0] pat, input int len, input logic ovl, input logic clr);
    int g;
    bit hit;
    @(negedge clk);
    ch_valid = v; ch_bit = b; cfg_we = we; cfg_pattern = pat;
    cfg_len = 4'(len); cfg_overlap = ovl; count_clr = clr;
    g = -1;
    if (!we) begin
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (m_ptr + k) % NCH;
        if (g < 0 && v[c]) g = c;
      end
    end
    exp_ready = (g < 0) ? '0 : NCH'(1 << g);
    #1 obs_ready = ch_ready;
    @(posedge clk);
    if (clr) m_cnt = 0;
    else if (m_mv && m_cnt < CMAX) m_cnt = m_cnt + 1;
    hit = 1'b0;
    if (we) begin
      m_pat = pat; m_len = (len > ML) ? ML : len; m_ovl = ovl;
      for (int i = 0; i < NCH; i++) m_fresh[i] = 0;
    end else if (g >= 0) begin
      m_seq[g][m_n[g]] = b[g];
      m_n[g]     = m_n[g] + 1;
      m_fresh[g] = m_fresh[g] + 1;
      hit = (m_len > 0) && (m_fresh[g] >= m_len);
      if (hit) begin
        for (int k = 0; k < m_len; k++)
          if (m_seq[g][m_n[g] - 1 - k] != m_pat[k]) hit = 1'b0;
      end
      if (hit && !m_ovl) m_fresh[g] = 0;
      m_ptr = (g + 1) % NCH;
    end
    m_mv = hit;
    if (hit) m_mch = g;
    exp_mv = m_mv; exp_mch = 2'(m_mch); exp_cnt = CW'(m_cnt);
    #1;
    obs_mv = match_valid; obs_mch = match_ch; obs_cnt = match_count;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ch_valid = '0; ch_bit = '0; cfg_we = 1'b0; count_clr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (ch_ready !== 4'b0000) $display("FAIL reset_ready got=%b exp=0000", ch_ready); else n_pass++;
    n_checks++; if (match_valid !== 1'b0) $display("FAIL reset_mv got=%b exp=0", match_valid); else n_pass++;
    n_checks++; if (match_ch !== 2'd0) $display("FAIL reset_mch got=%0d exp=0", match_ch); else n_pass++;
    n_checks++; if (match_count !== '0) $display("FAIL reset_cnt got=%0d exp=0", match_count); else n_pass++;
  endtask

  task automatic test_overlap_default();
    bit [7:0] s;
    int pulses;
    s = 8'b1101_1011;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick(4'b0001, {3'b000, s[7 - i]}, 1'b0, 8'h00, 0, 1'b0, 1'b0);
      n_checks++; if (obs_ready !== exp_ready) $display("FAIL ovl_ready i=%0d got=%b exp=%b", i, obs_ready, exp_ready); else n_pass++;
      n_checks++; if (obs_mv !== exp_mv) $display("FAIL ovl_mv i=%0d got=%b exp=%b", i, obs_mv, exp_mv); else n_pass++;
      n_checks++; if (obs_mv !== ((i == 4) || (i == 7))) $display("FAIL ovl_mv_fixed i=%0d got=%b", i, obs_mv); else n_pass++;
      n_checks++; if (obs_mch !== exp_mch) $display("FAIL ovl_mch i=%0d got=%0d exp=%0d", i, obs_mch, exp_mch); else n_pass++;
      if (obs_mv === 1'b1) pulses++;
    end
    tick('0, '0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    n_checks++; if (obs_cnt !== CW'(2)) $display("FAIL ovl_count got=%0d exp=2", obs_cnt); else n_pass++;
    n_checks++; if (pulses != 2) $display("FAIL ovl_pulses got=%0d exp=2", pulses); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    bit [3:0] s;
    s = 4'b1101;
    for (int i = 0; i < 4; i++) tick(4'b1000, {s[3 - i], 3'b000}, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    @(negedge clk);
    ch_valid = 4'b1000; ch_bit = 4'b1000; rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (match_valid !== 1'b0) $display("FAIL rstmid_mv got=%b exp=0", match_valid); else n_pass++;
    n_checks++; if (match_count !== '0) $display("FAIL rstmid_cnt got=%0d exp=0", match_count); else n_pass++;
    @(negedge clk);
    rst = 1'b0; ch_valid = '0;
    model_reset();
    tick(4'b1000, 4'b1000, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    n_checks++; if (obs_mv !== 1'b0 || exp_mv !== 1'b0) $display("FAIL rstmid_ctx got=%b exp=0", obs_mv); else n_pass++;
  endtask

  task automatic test_no_overlap();
    bit [7:0] s;
    int c0;
    s = 8'b1101_1011;
    tick('0, '0, 1'b1, 8'b0001_1011, 5, 1'b0, 1'b0);
    c0 = int'(obs_cnt);
    for (int i = 0; i < 8; i++) begin
      tick(4'b0001, {3'b000, s[7 - i]}, 1'b0, 8'h00, 0, 1'b0, 1'b0);
      n_checks++; if (obs_mv !== exp_mv) $display("FAIL novl_mv i=%0d got=%b exp=%b", i, obs_mv, exp_mv); else n_pass++;
      n_checks++; if (obs_mv !== (i == 4)) $display("FAIL novl_mv_fixed i=%0d got=%b", i, obs_mv); else n_pass++;
    end
    tick('0, '0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    n_checks++; if (int'(obs_cnt) != c0 + 1) $display("FAIL novl_count got=%0d exp=%0d", obs_cnt, c0 + 1); else n_pass++;
  endtask

  task automatic test_interleave();
    bit [4:0] s;
    logic b;
    s = 5'b11011;
    do_reset();
    for (int t = 0; t < 11; t++) begin
      b = (t < 10) ? s[4 - t / 2] : 1'b0;
      tick((t < 10) ? 4'b0101 : 4'b0000, {1'b0, b, 1'b0, b}, 1'b0, 8'h00, 0, 1'b0, 1'b0);
      if (t < 10) begin
        n_checks++; if (obs_ready !== ((t % 2) ? 4'b0100 : 4'b0001)) $display("FAIL il_ready t=%0d got=%b", t, obs_ready); else n_pass++;
      end
      n_checks++; if (obs_mv !== exp_mv) $display("FAIL il_mv t=%0d got=%b exp=%b", t, obs_mv, exp_mv); else n_pass++;
      n_checks++; if (obs_mch !== exp_mch) $display("FAIL il_mch t=%0d got=%0d exp=%0d", t, obs_mch, exp_mch); else n_pass++;
    end
    n_checks++; if (obs_mch !== 2'd2) $display("FAIL il_last_tag got=%0d exp=2", obs_mch); else n_pass++;
  endtask

  task automatic test_cfg_midstream();
    bit [6:0]  pre;
    bit [10:0] post;
    pre  = 7'b1010101;
    post = 11'b010_1010_1010;
    for (int i = 0; i < 7; i++) tick(4'b0010, {2'b00, pre[6 - i], 1'b0}, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    tick(4'b0010, 4'b0010, 1'b1, 8'b1010_1010, 8, 1'b1, 1'b0);
    n_checks++; if (obs_ready !== 4'b0000) $display("FAIL cfgmid_ready got=%b exp=0000", obs_ready); else n_pass++;
    for (int i = 0; i < 11; i++) begin
      tick(4'b0010, {2'b00, post[10 - i], 1'b0}, 1'b0, 8'h00, 0, 1'b0, 1'b0);
      n_checks++; if (obs_mv !== exp_mv) $display("FAIL cfgmid_mv i=%0d got=%b exp=%b", i, obs_mv, exp_mv); else n_pass++;
      n_checks++; if (obs_mv !== ((i == 8) || (i == 10))) $display("FAIL cfgmid_mv_fixed i=%0d got=%b", i, obs_mv); else n_pass++;
    end
  endtask

  task automatic test_len_zero_clamp();
    bit [9:0] s;
    bit [7:0] p;
    s = 10'b11011_11011;
    p = 8'b1010_1010;
    tick('0, '0, 1'b1, 8'b0001_1011, 0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(4'b0100, {1'b0, s[9 - i], 2'b00}, 1'b0, 8'h00, 0, 1'b0, 1'b0);
      n_checks++; if (obs_ready !== 4'b0100) $display("FAIL len0_ready i=%0d got=%b exp=0100", i, obs_ready); else n_pass++;
      n_checks++; if (obs_mv !== 1'b0) $display("FAIL len0_mv i=%0d got=%b exp=0", i, obs_mv); else n_pass++;
    end
    tick('0, '0, 1'b1, 8'b1010_1010, 12, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(4'b0100, {1'b0, p[7 - i], 2'b00}, 1'b0, 8'h00, 0, 1'b0, 1'b0);
      n_checks++; if (obs_mv !== exp_mv) $display("FAIL len12_mv i=%0d got=%b exp=%b", i, obs_mv, exp_mv); else n_pass++;
      n_checks++; if (obs_mv !== (i == 7)) $display("FAIL len12_mv_fixed i=%0d got=%b", i, obs_mv); else n_pass++;
    end
  endtask

  task automatic test_saturation();
    tick('0, '0, 1'b1, 8'h01, 1, 1'b1, 1'b0);
    for (int i = 0; i < CMAX + 4; i++) begin
      tick(4'b0001, 4'b0001, 1'b0, 8'h00, 0, 1'b0, 1'b0);
      n_checks++; if (obs_cnt !== exp_cnt) $display("FAIL sat_cnt i=%0d got=%0d exp=%0d", i, obs_cnt, exp_cnt); else n_pass++;
    end
    n_checks++; if (obs_cnt !== CW'(CMAX)) $display("FAIL sat_hold got=%0d exp=%0d", obs_cnt, CMAX); else n_pass++;
    tick(4'b0001, 4'b0001, 1'b0, 8'h00, 0, 1'b0, 1'b1);
    n_checks++; if (obs_cnt !== '0) $display("FAIL clr_wins got=%0d exp=0", obs_cnt); else n_pass++;
    tick('0, '0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    n_checks++; if (obs_cnt !== CW'(1)) $display("FAIL clr_then_inc got=%0d exp=1", obs_cnt); else n_pass++;
  endtask

  task automatic test_random();
    logic [NCH-1:0] v, b;
    logic we, clr, ovl;
    logic [7:0] pat;
    int len;
    for (int t = 0; t < 400; t++) begin
      v   = NCH'($urandom);
      b   = NCH'($urandom);
      we  = ($urandom_range(0, 39) == 0);
      clr = ($urandom_range(0, 49) == 0);
      pat = 8'($urandom);
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 12) : $urandom_range(1, 3);
      ovl = 1'($urandom);
      if (t == 0) begin
        we = 1'b1; len = 2; pat = 8'h03;
      end
      tick(v, b, we, pat, len, ovl, clr);
      n_checks++; if (obs_ready !== exp_ready) $display("FAIL rnd_ready t=%0d got=%b exp=%b", t, obs_ready, exp_ready); else n_pass++;
      n_checks++; if (obs_mv !== exp_mv) $display("FAIL rnd_mv t=%0d got=%b exp=%b", t, obs_mv, exp_mv); else n_pass++;
      n_checks++; if (obs_mch !== exp_mch) $display("FAIL rnd_mch t=%0d got=%0d exp=%0d", t, obs_mch, exp_mch); else n_pass++;
      n_checks++; if (obs_cnt !== exp_cnt) $display("FAIL rnd_cnt t=%0d got=%0d exp=%0d", t, obs_cnt, exp_cnt); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    ch_valid = '0; ch_bit = '0; count_clr = 1'b0;
    model_reset();
    test_reset();
    test_overlap_default();
    test_reset_midstream();
    test_no_overlap();
    test_interleave();
    test_cfg_midstream();
    test_len_zero_clamp();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
